instr_program_loader: RTL and testbench

- Assembles 16-bit instructions from field-level requests, the inverse of the control FSM's Decode step.
- Writes the assembled words sequentially into instruction memory over a valid/ready stream.
- Holds the processor in its Init state (processor Rst low) during loading.
- Releases the processor once the program is complete, optionally appending a HALT.

---
 rtl/isa_pkg.sv | 31 +++
 rtl/instr_word_encoder.sv | 29 ++
 rtl/instr_program_loader.sv | 152 +++++++++++++++
 tb/tb_instr_program_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode fields, loader request ops, loader states.
// Later Decode logic imports these same constants.
package isa_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [15:0] HALT_WORD = 16'h5000;

  typedef enum logic [2:0] {
    REQ_NOOP  = 3'd0,
    REQ_STORE = 3'd1,
    REQ_LOAD  = 3'd2,
    REQ_ADD   = 3'd3,
    REQ_SUB   = 3'd4,
    REQ_HALT  = 3'd5
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_APPEND = 3'd2,
    S_RUN    = 3'd3,
    S_ERR    = 3'd4
  } ld_state_e;

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational encoder: request op + fields -> 16-bit instruction word.
// Fields an opcode does not use stay 0; op codes 6 and 7 flag illegal.
module instr_word_encoder
  import isa_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [3:0]  i_ra,
  input  logic [3:0]  i_rb,
  input  logic [3:0]  i_rw,
  input  logic [7:0]  i_daddr,
  output logic [15:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = 16'h0000;
    o_illegal = 1'b0;
    case (i_op)
      REQ_NOOP:  o_word = {OP_NOOP, 12'h000};
      REQ_STORE: o_word = {OP_STORE, i_ra, i_daddr};
      REQ_LOAD:  o_word = {OP_LOAD, i_daddr, i_rw};
      REQ_ADD:   o_word = {OP_ADD, i_ra, i_rb, i_rw};
      REQ_SUB:   o_word = {OP_SUB, i_ra, i_rb, i_rw};
      REQ_HALT:  o_word = HALT_WORD;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_program_loader.sv
// Streams encoded instructions into instruction memory while holding the
// processor in reset, then releases it (optionally appending a HALT).
module instr_program_loader
  import isa_pkg::*;
#(
  parameter int unsigned IADDR_W   = 7,
  parameter int unsigned FILL_HALT = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Load_start,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic               In_last,
  input  logic [2:0]         In_op,
  input  logic [3:0]         In_ra,
  input  logic [3:0]         In_rb,
  input  logic [3:0]         In_rw,
  input  logic [7:0]         In_daddr,
  output logic               I_wr,
  output logic [IADDR_W-1:0] I_addr,
  output logic [15:0]        I_data,
  output logic               Cpu_rst_n,
  output logic               Done,
  output logic               Err,
  output logic [IADDR_W:0]   Word_cnt
);

  localparam int unsigned CNT_W = IADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'((1 << IADDR_W) - 1);

  ld_state_e          r_state;
  logic               r_in_ready;
  logic               r_wr;
  logic [IADDR_W-1:0] r_addr;
  logic [15:0]        r_data;
  logic               r_cpu_rst_n;
  logic               r_done;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic [15:0] w_word;
  logic        w_illegal;
  logic        w_accept;
  logic        w_full;
  logic        w_need_append;

  instr_word_encoder u_enc (
    .i_op      (In_op),
    .i_ra      (In_ra),
    .i_rb      (In_rb),
    .i_rw      (In_rw),
    .i_daddr   (In_daddr),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // The word counter doubles as the write address since only legal beats write.
  assign w_accept      = In_valid & r_in_ready;
  assign w_full        = (r_cnt == LAST_ADDR);
  assign w_need_append = (FILL_HALT != 0) && (w_word != HALT_WORD);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_data      <= 16'h0000;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (Load_start) begin
            r_state     <= S_LOAD;
            r_in_ready  <= 1'b1;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_err <= 1'b1;
              if (In_last) begin
                r_state    <= S_ERR;
                r_in_ready <= 1'b0;
              end
            end else begin
              r_wr   <= 1'b1;
              r_addr <= IADDR_W'(r_cnt);
              r_data <= w_word;
              r_cnt  <= r_cnt + CNT_W'(1);
              if (In_last && w_need_append) begin
                r_in_ready <= 1'b0;
                if (w_full) begin
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
                end else begin
                  r_state <= S_APPEND;
                end
              end else if (In_last) begin
                r_in_ready <= 1'b0;
                if (r_err) begin
                  r_state <= S_ERR;
                end else begin
                  r_state     <= S_RUN;
                  r_done      <= 1'b1;
                  r_cpu_rst_n <= 1'b1;
                end
              end else if (w_full) begin
                r_in_ready <= 1'b0;
                r_err      <= 1'b1;
                r_state    <= S_ERR;
              end
            end
          end
        end
        S_APPEND: begin
          r_wr   <= 1'b1;
          r_addr <= IADDR_W'(r_cnt);
          r_data <= HALT_WORD;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_err) begin
            r_state <= S_ERR;
          end else begin
            r_state     <= S_RUN;
            r_done      <= 1'b1;
            r_cpu_rst_n <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign In_ready  = r_in_ready;
  assign I_wr      = r_wr;
  assign I_addr    = r_addr;
  assign I_data    = r_data;
  assign Cpu_rst_n = r_cpu_rst_n;
  assign Done      = r_done;
  assign Err       = r_err;
  assign Word_cnt  = r_cnt;

endmodule

// File: tb/tb_instr_program_loader.sv
// Scoreboard bench: a default loader (IADDR_W=7) and a tiny one (IADDR_W=2)
// share the beat bus; each has its own Load_start and expected-write queue.
module tb_instr_program_loader;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic       ls_m, ls_s, in_valid, in_last;
  logic [2:0] in_op;
  logic [3:0] in_ra, in_rb, in_rw;
  logic [7:0] in_daddr;

  logic        m_ready, m_wr, m_cpu, m_done, m_err;
  logic [6:0]  m_addr;
  logic [15:0] m_data;
  logic [7:0]  m_cnt;

  logic        s_ready, s_wr, s_cpu, s_done, s_err;
  logic [1:0]  s_addr;
  logic [15:0] s_data;
  logic [2:0]  s_cnt;

  instr_program_loader #(.IADDR_W(7), .FILL_HALT(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .Load_start(ls_m), .In_valid(in_valid), .In_ready(m_ready),
    .In_last(in_last), .In_op(in_op), .In_ra(in_ra), .In_rb(in_rb), .In_rw(in_rw),
    .In_daddr(in_daddr), .I_wr(m_wr), .I_addr(m_addr), .I_data(m_data),
    .Cpu_rst_n(m_cpu), .Done(m_done), .Err(m_err), .Word_cnt(m_cnt)
  );

  instr_program_loader #(.IADDR_W(2), .FILL_HALT(1)) u_small (
    .Clk(Clk), .Rst(Rst), .Load_start(ls_s), .In_valid(in_valid), .In_ready(s_ready),
    .In_last(in_last), .In_op(in_op), .In_ra(in_ra), .In_rb(in_rb), .In_rw(in_rw),
    .In_daddr(in_daddr), .I_wr(s_wr), .I_addr(s_addr), .I_data(s_data),
    .Cpu_rst_n(s_cpu), .Done(s_done), .Err(s_err), .Word_cnt(s_cnt)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t q_m[$];
  wr_t q_s[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  exp_addr[2];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoding: {illegal, word}
  function automatic logic [16:0] enc(input logic [2:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] w,
                                      input logic [7:0] d);
    case (op)
      3'd0:    enc = 17'h00000;
      3'd1:    enc = {1'b0, 4'h1, a, d};
      3'd2:    enc = {1'b0, 4'h2, d, w};
      3'd3:    enc = {1'b0, 4'h3, a, b, w};
      3'd4:    enc = {1'b0, 4'h4, a, b, w};
      3'd5:    enc = {1'b0, 16'h5000};
      default: enc = {1'b1, 16'h0000};
    endcase
  endfunction

  task automatic push_wr(input bit sel, input int addr, input int data, input int c);
    wr_t e;
    e = '{addr, data, c};
    if (sel) q_s.push_back(e);
    else     q_m.push_back(e);
  endtask

  // Write monitors: one-cycle latency is enforced through the cycle stamp.
  always @(negedge Clk) begin
    wr_t e;
    if (m_wr === 1'b1) begin
      if (q_m.size() == 0) chk("m_unexp_wr", {25'd0, m_addr}, 32'hFFFF_FFFF);
      else begin
        e = q_m.pop_front();
        chk("m_waddr", 32'(m_addr), e.addr);
        chk("m_wdata", 32'(m_data), e.data);
        chk("m_wlat", cyc, e.cyc);
      end
    end else if (q_m.size() > 0 && q_m[0].cyc <= cyc) begin
      e = q_m.pop_front();
      chk("m_missing_wr", 32'(m_wr), 32'd1);
    end
  end

  always @(negedge Clk) begin
    wr_t e;
    if (s_wr === 1'b1) begin
      if (q_s.size() == 0) chk("s_unexp_wr", {30'd0, s_addr}, 32'hFFFF_FFFF);
      else begin
        e = q_s.pop_front();
        chk("s_waddr", 32'(s_addr), e.addr);
        chk("s_wdata", 32'(s_data), e.data);
        chk("s_wlat", cyc, e.cyc);
      end
    end else if (q_s.size() > 0 && q_s[0].cyc <= cyc) begin
      e = q_s.pop_front();
      chk("s_missing_wr", 32'(s_wr), 32'd1);
    end
  end

  task automatic chk_state(input string tag, input bit sel, input logic rdy, input logic cpu,
                           input logic done, input logic err, input int cnt);
    if (sel) begin
      chk({tag, "_rdy"}, 32'(s_ready), 32'(rdy));
      chk({tag, "_cpu"}, 32'(s_cpu), 32'(cpu));
      chk({tag, "_done"}, 32'(s_done), 32'(done));
      chk({tag, "_err"}, 32'(s_err), 32'(err));
      chk({tag, "_cnt"}, 32'(s_cnt), cnt);
    end else begin
      chk({tag, "_rdy"}, 32'(m_ready), 32'(rdy));
      chk({tag, "_cpu"}, 32'(m_cpu), 32'(cpu));
      chk({tag, "_done"}, 32'(m_done), 32'(done));
      chk({tag, "_err"}, 32'(m_err), 32'(err));
      chk({tag, "_cnt"}, 32'(m_cnt), cnt);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) ls_s = 1'b1;
    else     ls_m = 1'b1;
    @(posedge Clk); #1;
    ls_s = 1'b0;
    ls_m = 1'b0;
    exp_addr[sel] = 0;
  endtask

  // Drive one beat and wait (bounded) for the selected loader to take it.
  task automatic send_beat(input bit sel, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] w, input logic [7:0] d,
                           input logic last);
    bit          acc;
    int          budget;
    logic [16:0] e;
    in_op = op; in_ra = a; in_rb = b; in_rw = w; in_daddr = d;
    in_last = last; in_valid = 1'b1;
    acc = 1'b0; budget = 0;
    while (!acc && budget < 20) begin
      acc = sel ? s_ready : m_ready;
      @(posedge Clk); #1;
      budget++;
    end
    if (!acc) chk("beat_timeout", 32'd0, 32'd1);
    else begin
      e = enc(op, a, b, w, d);
      if (!e[16]) begin
        push_wr(sel, exp_addr[sel], 32'(e[15:0]), cyc);
        exp_addr[sel]++;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    Rst = 1'b1;
    ls_m = 1'b0; ls_s = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = 3'd0; in_ra = 4'd0; in_rb = 4'd0; in_rw = 4'd0; in_daddr = 8'd0;
    exp_addr[0] = 0; exp_addr[1] = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk_state("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("rst_wr", 32'(m_wr), 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    Rst = 1'b0;
    idle(2);

    // Back-to-back ADD, SUB, HALT(last)
    pulse_start(1'b0);
    chk_state("start1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_beat(1'b0, 3'd3, 4'd1, 4'd2, 4'd3, 8'h00, 1'b0);
    send_beat(1'b0, 3'd4, 4'd4, 4'd5, 4'd6, 8'h00, 1'b0);
    send_beat(1'b0, 3'd5, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1);
    chk_state("run1_entry", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    idle(3);
    chk_state("run1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);

    // Restart from RUN, STORE then LOAD(last) with HALT appended
    pulse_start(1'b0);
    chk_state("restart", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_beat(1'b0, 3'd1, 4'd7, 4'd0, 4'd0, 8'hA5, 1'b0);
    send_beat(1'b0, 3'd2, 4'd0, 4'd0, 4'd9, 8'h3C, 1'b1);
    push_wr(1'b0, exp_addr[0], 32'h5000, cyc + 1);
    exp_addr[0]++;
    chk("append_rdy", 32'(m_ready), 32'd0);
    chk("append_cpu", 32'(m_cpu), 32'd0);
    idle(3);
    chk_state("run2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);

    // Illegal op mid-stream, then HALT(last) -> ERR
    pulse_start(1'b0);
    send_beat(1'b0, 3'd3, 4'd8, 4'd9, 4'd10, 8'h00, 1'b0);
    send_beat(1'b0, 3'd6, 4'd1, 4'd1, 4'd1, 8'h11, 1'b0);
    chk("illegal_err", 32'(m_err), 32'd1);
    chk("illegal_cnt", 32'(m_cnt), 32'd1);
    send_beat(1'b0, 3'd5, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1);
    idle(3);
    chk_state("err3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);

    // Reset asserted while beats are flowing
    pulse_start(1'b0);
    send_beat(1'b0, 3'd4, 4'd3, 4'd2, 4'd1, 8'h00, 1'b0);
    in_op = 3'd3; in_ra = 4'd5; in_rb = 4'd5; in_rw = 4'd5;
    @(negedge Clk); #1;
    Rst = 1'b1;
    #1;
    chk_state("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("mid_rst_wr", 32'(m_wr), 32'd0);
    chk("mid_rst_addr", 32'(m_addr), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    chk_state("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(1);
    pulse_start(1'b0);
    send_beat(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    send_beat(1'b0, 3'd5, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1);
    idle(3);
    chk_state("run4", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);

    // Tiny memory: four beats without last overflow into ERR
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++)
      send_beat(1'b1, 3'd3, 4'(i), 4'(i + 1), 4'(i + 2), 8'h00, 1'b0);
    repeat (3) begin
      @(posedge Clk); #1;
    end
    chk_state("full", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    idle(1);

    // Tiny memory: last beat needs an append that does not fit
    pulse_start(1'b1);
    chk_state("s_restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      send_beat(1'b1, 3'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    send_beat(1'b1, 3'd3, 4'd1, 4'd2, 4'd3, 8'h00, 1'b1);
    idle(3);
    chk_state("no_room", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4);

    // Tiny memory: HALT as the fourth word fits exactly
    pulse_start(1'b1);
    for (int i = 0; i < 3; i++)
      send_beat(1'b1, 3'd2, 4'd0, 4'd0, 4'(i), 8'(8'h10 + i), 1'b0);
    send_beat(1'b1, 3'd5, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1);
    idle(3);
    chk_state("s_run", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4);

    chk("m_q_empty", 32'(q_m.size()), 32'd0);
    chk("s_q_empty", 32'(q_s.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
